sm_segment_fetcher: RTL and testbench
=====================================

Name: sm_segment_fetcher

Overview:
Upstream feeder for the sparse-map decoder.
- Walks a compressed segment stream in pixel memory. Per segment: one 16-bit significance-map (SM) word, then popcount(SM) non-zero value (NZV) words.
- Latches SM, computes its Hamming weight, buffers the NZV words in a local FIFO, then launches the decoder.
- Waits for the decoder to drain the segment before fetching the next one.

Parameters:
ADDR_W, 16, pixel-memory word-address width
DATA_W, 16, memory/NZV word width
FIFO_DEPTH, 16, NZV buffer depth (must be >=16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_start  in  1  start pulse, sampled in IDLE only
base_addr  in  ADDR_W  address of first SM word, latched on op_start
seg_count  in  16  number of segments, latched on op_start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after last segment completes
mem_req  out  1  bus request / bus hold
mem_grant  in  1  bus grant
mem_addr  out  ADDR_W  current read address
mem_rd_rdy  out  1  fetcher can accept a read beat
mem_rd_vld  in  1  read data valid
mem_data  in  DATA_W  read data
sm_out  out  16  latched SM of current segment
hamw_out  out  5  popcount(sm_out), 0..16
dec_start  out  1  one-cycle decoder launch pulse
dec_busy  in  1  decoder busy
nzv_out  out  DATA_W  FIFO head (first-word-fall-through)
nzv_read  in  1  pop FIFO head
nzv_empty  out  1  FIFO empty

Behaviour:
- Reset values:
  - State IDLE; all control outputs 0.
  - sm_out=0, hamw_out=0, mem_addr=0.
  - FIFO cleared, nzv_empty=1.
  - Reset mid-operation drops mem_req immediately (async) and discards all buffered data.
- Beat rule: a read beat completes when mem_rd_vld & mem_rd_rdy. On each beat, the address pointer increments by 1, wrapping modulo 2^ADDR_W.
- States and transitions:
  - IDLE: on op_start, latch base_addr into the pointer and seg_count into the remaining-count register. If seg_count==0, go to DONE; else go to REQ. op_start in any other state is ignored.
  - REQ: mem_req=1. On mem_grant, go to RD_SM.
  - RD_SM: mem_req=1, mem_rd_rdy=1. On a beat, sm_out<=mem_data and hamw_out<=popcount(mem_data), combinational adder tree, registered.
    - hamw 0 goes to LAUNCH with mem_req released; see optional feature.
    - hamw non-zero goes to RD_NZV with the beat counter set to hamw.
  - RD_NZV: mem_req=1, mem_rd_rdy=1. Each beat pushes mem_data to the FIFO and decrements the counter. The last beat goes to LAUNCH, and mem_req drops the cycle after the last beat.
  - LAUNCH: dec_start=1 for exactly one cycle, then WAIT_DEC.
  - WAIT_DEC: leave when dec_busy==0 && nzv_empty. Decrement the remaining count. If the count is now 0, go to DONE; else go to REQ.
  - DONE: done=1 for one cycle, then IDLE.
- Latencies:
  - op_start to mem_req high: 1 cycle.
  - Last NZV beat to dec_start: 1 cycle.
  - WAIT_DEC exit to next mem_req: 1 cycle.
- sm_out/hamw_out hold stable from the RD_SM beat until the next segment's RD_SM beat, so the decoder may sample them at any time while busy.
- Bus ownership: mem_req is held continuously from grant through the last beat of a segment. A grant that drops mid-segment is not re-checked; the arbiter guarantees hold-while-requested.
- FIFO:
  - Push only in RD_NZV.
  - nzv_read while empty is ignored, with no pointer underflow.
  - Overflow is impossible since hamw <= 16 <= FIFO_DEPTH.
  - A push and a pop in the same cycle cannot occur by construction: the decoder is not started until all NZVs are loaded.
- An unmatched mem_rd_vld (mem_rd_rdy low) is not consumed and not counted.

Optional Feature:
ZERO_SEG_SKIP_EN
- Defined: a segment with SM==0 bypasses LAUNCH/WAIT_DEC. RD_SM goes directly to the remaining-count decrement, then REQ or DONE. No dec_start is issued, and sm_out/hamw_out still update to 0.
- Undefined: an SM==0 segment issues dec_start with hamw_out=0 and waits for dec_busy low as normal.

Test Plan:
- Reset mid-RD_NZV after 3 of 5 beats, then release reset -> mem_req=0, nzv_empty=1, busy=0, sm_out=0; a new op_start restarts from the new base_addr.
- base_addr=0x0100, seg_count=1, memory {0x8003, 0xAAAA, 0xBBBB, 0xCCCC} -> sm_out=0x8003, hamw_out=3, three FIFO pushes, dec_start one cycle after the last beat; after pops and dec_busy low, done pulses and the final pointer is 0x0104.
- seg_count=0 -> no mem_req, done pulses 2 cycles after op_start, busy high exactly those 2 cycles.
- SM=0xFFFF -> hamw_out=16, 16 NZV beats, FIFO holds 16 entries; mem_rd_vld gaps of 2 cycles between beats are tolerated.
- Two segments, first SM=0x0000, second SM=0x4000 with value 0x1234:
  - ZERO_SEG_SKIP_EN defined -> one dec_start.
  - Undefined -> two dec_starts, the first with hamw_out=0.
- base_addr=0xFFFE, SM=0x0001 -> addresses 0xFFFE, 0xFFFF; pointer wraps to 0x0000; nzv_read while empty leaves nzv_empty=1 with no corruption.

Source files
------------

// File: rtl/sm_segment_fetcher.sv
// sm_segment_fetcher: walks SM/NZV segments in pixel memory, buffers the NZVs and launches the sparse-map decoder.
// Build option ZERO_SEG_SKIP_EN: segments whose SM is zero skip the decoder launch.
module sm_segment_fetcher #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       seg_count,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_rdy,
    input  logic              mem_rd_vld,
    input  logic [DATA_W-1:0] mem_data,
    output logic [15:0]       sm_out,
    output logic [4:0]        hamw_out,
    output logic              dec_start,
    input  logic              dec_busy,
    output logic [DATA_W-1:0] nzv_out,
    input  logic              nzv_read,
    output logic              nzv_empty
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_SM,
        S_RD_NZV,
        S_LAUNCH,
        S_WAIT_DEC,
        S_DONE
    } state_t;

    state_t             state;
    logic [15:0]        remaining;
    logic [4:0]         beat_cnt;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               beat;
    logic               push;
    logic               pop;
    logic [15:0]        sm_c;
    logic [4:0]         hamw_c;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s = s + 5'(v[i]);
        end
        return s;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign beat    = mem_rd_vld & mem_rd_rdy;
    assign sm_c    = mem_data[15:0];
    assign hamw_c  = popcount16(sm_c);
    assign push    = beat && (state == S_RD_NZV);
    assign pop     = nzv_read && !nzv_empty;
    assign nzv_out = fifo_mem[rd_ptr];

    // Segment walker; every output is registered from the transition it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= '0;
            beat_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            mem_rd_rdy <= 1'b0;
            mem_addr   <= '0;
            sm_out     <= '0;
            hamw_out   <= '0;
            dec_start  <= 1'b0;
        end else begin
            dec_start <= 1'b0;
            done      <= 1'b0;
            if (beat) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    busy <= op_start;
                    if (op_start) begin
                        mem_addr  <= base_addr;
                        remaining <= seg_count;
                        if (seg_count == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_grant) begin
                        state      <= S_RD_SM;
                        mem_rd_rdy <= 1'b1;
                    end
                end
                S_RD_SM: begin
                    if (beat) begin
                        sm_out   <= sm_c;
                        hamw_out <= hamw_c;
                        if (hamw_c == 5'd0) begin
                            mem_rd_rdy <= 1'b0;
`ifdef ZERO_SEG_SKIP_EN
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state   <= S_DONE;
                                mem_req <= 1'b0;
                            end else begin
                                state <= S_REQ;
                            end
`else
                            mem_req   <= 1'b0;
                            dec_start <= 1'b1;
                            state     <= S_LAUNCH;
`endif
                        end else begin
                            beat_cnt <= hamw_c;
                            state    <= S_RD_NZV;
                        end
                    end
                end
                S_RD_NZV: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt - 5'd1;
                        if (beat_cnt == 5'd1) begin
                            mem_req    <= 1'b0;
                            mem_rd_rdy <= 1'b0;
                            dec_start  <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_DEC;
                end
                S_WAIT_DEC: begin
                    if (!dec_busy && nzv_empty) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // NZV buffer, first-word-fall-through; reads of an empty buffer are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            nzv_empty <= 1'b1;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt  <= fifo_cnt + CNT_W'(1);
                nzv_empty <= 1'b0;
            end else if (pop && !push) begin
                fifo_cnt  <= fifo_cnt - CNT_W'(1);
                nzv_empty <= (fifo_cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_sm_segment_fetcher.sv
// Scoreboard bench for sm_segment_fetcher: memory/arbiter/decoder models plus a queue-based monitor.
module tb_sm_segment_fetcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] seg_count = '0;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_grant = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd_rdy;
    logic        mem_rd_vld = 1'b0;
    logic [15:0] mem_data = '0;
    logic [15:0] sm_out;
    logic [4:0]  hamw_out;
    logic        dec_start;
    logic        dec_busy = 1'b0;
    logic [15:0] nzv_out;
    logic        nzv_read = 1'b0;
    logic        nzv_empty;

    logic [15:0] mem_m [0:65535];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_sm[$];
    int          exp_hw[$];
    logic [15:0] exp_nzv[$];
    logic [15:0] exp_done[$];

    int n_total = 0;
    int n_bad = 0;
    int beat_seen = 0;
    bit gap_mode = 1'b0;
    bit force_rd = 1'b0;

    sm_segment_fetcher dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .base_addr(base_addr),
        .seg_count(seg_count), .busy(busy), .done(done), .mem_req(mem_req),
        .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_rd_rdy(mem_rd_rdy),
        .mem_rd_vld(mem_rd_vld), .mem_data(mem_data), .sm_out(sm_out),
        .hamw_out(hamw_out), .dec_start(dec_start), .dec_busy(dec_busy),
        .nzv_out(nzv_out), .nzv_read(nzv_read), .nzv_empty(nzv_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: walk memory by the segment rules and queue every expected observation.
    task automatic build_expect(input logic [15:0] base, input int segs);
        logic [15:0] p;
        logic [15:0] sm;
        int hw;
        p = base;
        for (int s = 0; s < segs; s++) begin
            sm = mem_m[p];
            exp_addr.push_back(p);
            p = p + 16'd1;
            hw = $countones(sm);
`ifdef ZERO_SEG_SKIP_EN
            if (hw != 0) begin
                exp_sm.push_back(sm);
                exp_hw.push_back(hw);
            end
`else
            exp_sm.push_back(sm);
            exp_hw.push_back(hw);
`endif
            for (int k = 0; k < hw; k++) begin
                exp_addr.push_back(p);
                exp_nzv.push_back(mem_m[p]);
                p = p + 16'd1;
            end
        end
        exp_done.push_back(p);
    endtask

    task automatic fill_random(input logic [15:0] base, input int segs);
        logic [15:0] p;
        logic [15:0] sm;
        p = base;
        for (int s = 0; s < segs; s++) begin
            sm = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
            mem_m[p] = sm;
            p = p + 16'd1;
            for (int k = 0; k < $countones(sm); k++) begin
                mem_m[p] = 16'($urandom);
                p = p + 16'd1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk); #1;
            if (done) break;
            n++;
        end
        check("done_seen", 32'(n < budget), 1);
        repeat (3) @(negedge clk);
        check("queues_drained", exp_addr.size() + exp_sm.size() + exp_nzv.size() + exp_done.size(), 0);
    endtask

    // Second op_start cycle (poke) carries junk that must be ignored once the walk has begun.
    task automatic run_op(input logic [15:0] base, input logic [15:0] segs, input bit poke);
        build_expect(base, int'(segs));
        @(posedge clk); #1;
        base_addr = base;
        seg_count = segs;
        op_start  = 1'b1;
        @(posedge clk); #1;
        if (poke) begin
            base_addr = ~base;
            seg_count = 16'd7;
            @(posedge clk); #1;
        end
        op_start = 1'b0;
        wait_done(3000);
    endtask

    // Memory slave, arbiter and decoder models; inputs change just after the active edge.
    initial begin
        int dec_cnt;
        int env_cyc;
        bit dec_active;
        dec_cnt = 0;
        env_cyc = 0;
        dec_active = 1'b0;
        forever begin
            @(posedge clk); #1;
            env_cyc++;
            if (!rst_n) begin
                mem_grant  = 1'b0;
                mem_rd_vld = 1'b0;
                dec_busy   = 1'b0;
                nzv_read   = 1'b0;
                dec_active = 1'b0;
            end else begin
                mem_grant  = mem_req ? (mem_grant | ($urandom_range(0, 2) == 0)) : 1'b0;
                mem_rd_vld = gap_mode ? (env_cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
                mem_data   = mem_rd_vld ? mem_m[mem_addr] : 16'hDEAD;
                nzv_read   = force_rd;
                if (dec_start) begin
                    dec_active = 1'b1;
                    dec_busy   = 1'b1;
                    dec_cnt    = $urandom_range(0, 3);
                end else if (dec_active) begin
                    if (dec_cnt > 0) begin
                        dec_cnt--;
                    end else if (!nzv_empty) begin
                        nzv_read = 1'b1;
                    end else begin
                        dec_busy   = 1'b0;
                        dec_active = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat, launch, NZV pop or done.
    initial begin
        int cyc;
        int last_beat_cyc;
        cyc = 0;
        last_beat_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (dec_start) begin
                    check("launch_latency", 32'(cyc - last_beat_cyc), 1);
                    check("mem_req_at_launch", 32'(mem_req), 0);
                    check("launch_expected", 32'(exp_sm.size() != 0), 1);
                    if (exp_sm.size() != 0) begin
                        check("sm_out", 32'(sm_out), 32'(exp_sm.pop_front()));
                        check("hamw_out", 32'(hamw_out), 32'(exp_hw.pop_front()));
                    end
                end
                if (mem_rd_vld && mem_rd_rdy) begin
                    beat_seen++;
                    last_beat_cyc = cyc;
                    check("beat_expected", 32'(exp_addr.size() != 0), 1);
                    if (exp_addr.size() != 0) check("beat_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                end
                if (nzv_read && !nzv_empty) begin
                    check("nzv_expected", 32'(exp_nzv.size() != 0), 1);
                    if (exp_nzv.size() != 0) check("nzv_out", 32'(nzv_out), 32'(exp_nzv.pop_front()));
                end
                if (done) begin
                    check("busy_at_done", 32'(busy), 1);
                    check("done_expected", 32'(exp_done.size() != 0), 1);
                    if (exp_done.size() != 0) check("final_ptr", 32'(mem_addr), 32'(exp_done.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        for (int i = 0; i < 65536; i++) mem_m[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_rd_rdy", 32'(mem_rd_rdy), 0);
        check("rst_dec_start", 32'(dec_start), 0);
        check("rst_sm_out", 32'(sm_out), 0);
        check("rst_hamw_out", 32'(hamw_out), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_nzv_empty", 32'(nzv_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single segment with three NZVs
        mem_m[16'h0100] = 16'h8003;
        mem_m[16'h0101] = 16'hAAAA;
        mem_m[16'h0102] = 16'hBBBB;
        mem_m[16'h0103] = 16'hCCCC;
        run_op(16'h0100, 16'd1, 1'b0);
        check("t1_sm_hold", 32'(sm_out), 32'h8003);
        check("t1_hamw_hold", 32'(hamw_out), 3);
        check("t1_final_addr", 32'(mem_addr), 32'h0104);

        // Zero segments: straight to done, busy for exactly two cycles
        exp_done.push_back(16'h0600);
        @(posedge clk); #1;
        base_addr = 16'h0600;
        seg_count = 16'd0;
        op_start  = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        @(negedge clk);
        check("z_busy1", 32'(busy), 1);
        check("z_done1", 32'(done), 0);
        check("z_req1", 32'(mem_req), 0);
        @(negedge clk);
        check("z_busy2", 32'(busy), 1);
        check("z_done2", 32'(done), 1);
        check("z_req2", 32'(mem_req), 0);
        @(negedge clk);
        check("z_busy3", 32'(busy), 0);
        check("z_done3", 32'(done), 0);

        // Full SM with two-cycle gaps between read beats
        mem_m[16'h0500] = 16'hFFFF;
        for (int k = 1; k <= 16; k++) mem_m[16'h0500 + 16'(k)] = 16'($urandom);
        gap_mode = 1'b1;
        run_op(16'h0500, 16'd1, 1'b0);
        gap_mode = 1'b0;
        check("full_hamw", 32'(hamw_out), 16);

        // Zero SM followed by a single-NZV segment
        mem_m[16'h0400] = 16'h0000;
        mem_m[16'h0401] = 16'h4000;
        mem_m[16'h0402] = 16'h1234;
        run_op(16'h0400, 16'd2, 1'b0);

        // Address wrap, then a read of the empty buffer
        mem_m[16'hFFFE] = 16'h0001;
        mem_m[16'hFFFF] = 16'h5A5A;
        run_op(16'hFFFE, 16'd1, 1'b0);
        check("wrap_addr", 32'(mem_addr), 32'h0000);
        @(posedge clk); #1;
        force_rd = 1'b1;
        @(posedge clk); #1;
        force_rd = 1'b0;
        @(negedge clk);
        check("empty_read_empty", 32'(nzv_empty), 1);

        // Reset after three of five NZV beats, then restart from a new base
        mem_m[16'h0200] = 16'h001F;
        for (int k = 1; k <= 5; k++) mem_m[16'h0200 + 16'(k)] = 16'h7000 + 16'(k);
        build_expect(16'h0200, 1);
        b0 = beat_seen;
        @(posedge clk); #1;
        base_addr = 16'h0200;
        seg_count = 16'd1;
        op_start  = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        n = 0;
        while (n < 500 && beat_seen < b0 + 4) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_mid_reached", 32'(n < 500), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_addr.delete();
        exp_sm.delete();
        exp_hw.delete();
        exp_nzv.delete();
        exp_done.delete();
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_nzv_empty", 32'(nzv_empty), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sm_out", 32'(sm_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_m[16'h0300] = 16'h0003;
        mem_m[16'h0301] = 16'h1111;
        mem_m[16'h0302] = 16'h2222;
        run_op(16'h0300, 16'd1, 1'b0);

        // Randomised multi-segment operations
        for (int r = 0; r < 8; r++) begin
            logic [15:0] rb;
            logic [15:0] rs;
            rb = 16'($urandom);
            rs = 16'($urandom_range(1, 4));
            fill_random(rb, int'(rs));
            run_op(rb, rs, r[0]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
